// File: rtl/cond_pkg.sv
// Shared types and helpers for the conditional-issue controller.
//   cond_e       : ARM condition field encodings (EQ..AL, NV)
//   FlagN..FlagV : bit positions of N/Z/C/V inside a {N,Z,C,V} flags vector
//   need_mask()  : which flag groups a condition reads, {nz, cv}
//   pipe_entry_t : one slot of the in-flight flag-writer shift register
package cond_pkg;

   typedef enum logic [3:0] {
      CondEq = 4'h0, CondNe = 4'h1, CondCs = 4'h2, CondCc = 4'h3,
      CondMi = 4'h4, CondPl = 4'h5, CondVs = 4'h6, CondVc = 4'h7,
      CondHi = 4'h8, CondLs = 4'h9, CondGe = 4'ha, CondLt = 4'hb,
      CondGt = 4'hc, CondLe = 4'hd, CondAl = 4'he, CondNv = 4'hf
   } cond_e;

   localparam int unsigned FlagN = 3;
   localparam int unsigned FlagZ = 2;
   localparam int unsigned FlagC = 1;
   localparam int unsigned FlagV = 0;

   typedef struct packed {
      logic       valid;
      logic [1:0] flagw;  // [1] = writes NZ, [0] = writes CV
   } pipe_entry_t;

   // Flag groups read by a condition: [1] = NZ, [0] = CV.
   function automatic logic [1:0] need_mask(input logic [3:0] cond);
      logic [1:0] m;
      case (cond_e'(cond))
         CondEq, CondNe, CondMi, CondPl:                 m = 2'b10;
         CondCs, CondCc, CondVs, CondVc:                 m = 2'b01;
         CondHi, CondLs, CondGe, CondLt, CondGt, CondLe: m = 2'b11;
         default:                                        m = 2'b00;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/cond_issue_ctrl_cond_eval.sv
// Combinational ARM condition evaluator.
//   cond_i  : 4-bit condition field
//   flags_i : {N,Z,C,V}
//   pass_o  : 1 when the condition holds; NV (4'b1111) always yields 0
module cond_issue_ctrl_cond_eval
   import cond_pkg::*;
(
   input  logic [3:0] cond_i,
   input  logic [3:0] flags_i,
   output logic       pass_o
);

   logic n, z, c, v;

   assign n = flags_i[FlagN];
   assign z = flags_i[FlagZ];
   assign c = flags_i[FlagC];
   assign v = flags_i[FlagV];

   always_comb begin
      pass_o = 1'b0;
      case (cond_e'(cond_i))
         CondEq:  pass_o = z;
         CondNe:  pass_o = ~z;
         CondCs:  pass_o = c;
         CondCc:  pass_o = ~c;
         CondMi:  pass_o = n;
         CondPl:  pass_o = ~n;
         CondVs:  pass_o = v;
         CondVc:  pass_o = ~v;
         CondHi:  pass_o = c & ~z;
         CondLs:  pass_o = ~c | z;
         CondGe:  pass_o = (n == v);
         CondLt:  pass_o = (n != v);
         CondGt:  pass_o = ~z & (n == v);
         CondLe:  pass_o = z | (n != v);
         CondAl:  pass_o = 1'b1;
         default: pass_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Issue-stage sequencer for ARM conditional execution.
// Owns the architectural NZCV register, tracks in-flight flag writers in an EX_LAT-deep
// shift register, stalls conditional instructions whose flags are still pending, and
// gates RegWrite/MemWrite/PCSrc with the evaluated condition.
//
// Build option: define COND_FLAG_BYPASS_EN to let a dependent instruction issue in the
// same cycle its only pending writer(s) sit at the pipe tail, using alu_flags forwarded
// through the tail's flagw mask. Undefined: dependents wait until flags are committed.
//
// Ports
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid / in_ready   : decode handshake (in_ready is combinational)
//   in_cond, in_flagw     : condition field, flag-group write mask {NZ, CV}
//   in_regw/memw/pcs      : decoded side-effect enables
//   alu_flags             : {N,Z,C,V} from the ALU, used only when flag_wb is high
//   flush                 : kill younger in-flight state (tail writeback still commits)
//   iss_*                 : registered issue result, one cycle after acceptance
//   flag_wb               : tail entry writes flags this cycle
//   flags                 : architectural {N,Z,C,V}
//   undef_err             : one-cycle pulse after a cond=1111 instruction is accepted
module cond_issue_ctrl
   import cond_pkg::*;
#(
   parameter int unsigned EX_LAT = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] in_cond,
   input  logic [1:0] in_flagw,
   input  logic       in_regw,
   input  logic       in_memw,
   input  logic       in_pcs,
   input  logic [3:0] alu_flags,
   input  logic       flush,
   output logic       iss_valid,
   output logic       iss_exec,
   output logic       iss_regw,
   output logic       iss_memw,
   output logic       iss_pcs,
   output logic       flag_wb,
   output logic [3:0] flags,
   output logic       undef_err
);

   localparam int unsigned CNT_W = $clog2(EX_LAT + 1);

   pipe_entry_t [EX_LAT-1:0] pipe_q, pipe_d;
   pipe_entry_t              tail;
   logic [CNT_W-1:0]         pend_nz_q, pend_nz_d, pend_cv_q, pend_cv_d;
   logic [3:0]               flags_q, flags_d, eval_flags;
   logic                     iss_valid_q, iss_exec_q, iss_regw_q, iss_memw_q, iss_pcs_q;
   logic                     undef_q;
   logic                     tail_nz, tail_cv;
   logic [1:0]               need;
   logic                     hz_nz, hz_cv;
   logic                     pass, acc, exec;
   logic [1:0]               new_fw;

   // Index EX_LAT-1 is the oldest entry; an entry accepted at T sits there at T+EX_LAT.
   assign tail    = pipe_q[EX_LAT-1];
   assign tail_nz = tail.valid & tail.flagw[1];
   assign tail_cv = tail.valid & tail.flagw[0];
   assign flag_wb = tail.valid;

   // Flags after this cycle's tail writeback; also the forwarded view for bypass.
   assign flags_d = {tail_nz ? alu_flags[3:2] : flags_q[3:2],
                     tail_cv ? alu_flags[1:0] : flags_q[1:0]};

   assign need = need_mask(in_cond);

`ifdef COND_FLAG_BYPASS_EN
   // A group is safe if its only pending writer is committing right now.
   assign hz_nz      = need[1] & (pend_nz_q != CNT_W'(tail_nz));
   assign hz_cv      = need[0] & (pend_cv_q != CNT_W'(tail_cv));
   assign eval_flags = flags_d;
`else
   assign hz_nz      = need[1] & (pend_nz_q != '0);
   assign hz_cv      = need[0] & (pend_cv_q != '0);
   assign eval_flags = flags_q;
`endif

   assign in_ready = ~(hz_nz | hz_cv) & ~flush;
   assign acc      = in_valid & in_ready;

   cond_issue_ctrl_cond_eval u_cond_eval (
      .cond_i  (in_cond),
      .flags_i (eval_flags),
      .pass_o  (pass)
   );

   assign exec   = acc & pass;
   // A squashed instruction never becomes a flag writer.
   assign new_fw = exec ? in_flagw : 2'b00;

   always_comb begin
      pipe_d          = pipe_q;
      pipe_d[0].valid = |new_fw;
      pipe_d[0].flagw = new_fw;
      for (int unsigned k = 1; k < EX_LAT; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end

      pend_nz_d = pend_nz_q;
      if (new_fw[1] & ~tail_nz) begin
         pend_nz_d = pend_nz_q + CNT_W'(1);
      end else if (tail_nz & ~new_fw[1]) begin
         pend_nz_d = pend_nz_q - CNT_W'(1);
      end

      pend_cv_d = pend_cv_q;
      if (new_fw[0] & ~tail_cv) begin
         pend_cv_d = pend_cv_q + CNT_W'(1);
      end else if (tail_cv & ~new_fw[0]) begin
         pend_cv_d = pend_cv_q - CNT_W'(1);
      end

      // The tail commits this cycle, so nothing remains outstanding after a flush.
      if (flush) begin
         pipe_d    = '0;
         pend_nz_d = '0;
         pend_cv_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pipe_q      <= '0;
         pend_nz_q   <= '0;
         pend_cv_q   <= '0;
         flags_q     <= '0;
         iss_valid_q <= 1'b0;
         iss_exec_q  <= 1'b0;
         iss_regw_q  <= 1'b0;
         iss_memw_q  <= 1'b0;
         iss_pcs_q   <= 1'b0;
         undef_q     <= 1'b0;
      end else begin
         pipe_q      <= pipe_d;
         pend_nz_q   <= pend_nz_d;
         pend_cv_q   <= pend_cv_d;
         flags_q     <= flags_d;
         iss_valid_q <= acc;
         iss_exec_q  <= exec;
         iss_regw_q  <= exec & in_regw;
         iss_memw_q  <= exec & in_memw;
         iss_pcs_q   <= exec & in_pcs;
         undef_q     <= acc & (in_cond == CondNv);
      end
   end

   assign iss_valid = iss_valid_q;
   assign iss_exec  = iss_exec_q;
   assign iss_regw  = iss_regw_q;
   assign iss_memw  = iss_memw_q;
   assign iss_pcs   = iss_pcs_q;
   assign flags     = flags_q;
   assign undef_err = undef_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed bench for cond_issue_ctrl (EX_LAT = 2). Inputs change 1 time unit after the
// rising edge; outputs are sampled before the next edge.
module tb_cond_issue_ctrl;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_cond;
   logic [1:0] in_flagw;
   logic       in_regw, in_memw, in_pcs;
   logic [3:0] alu_flags;
   logic       flush;
   logic       iss_valid, iss_exec, iss_regw, iss_memw, iss_pcs;
   logic       flag_wb;
   logic [3:0] flags;
   logic       undef_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cond_issue_ctrl #(.EX_LAT(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_cond   (in_cond),
      .in_flagw  (in_flagw),
      .in_regw   (in_regw),
      .in_memw   (in_memw),
      .in_pcs    (in_pcs),
      .alu_flags (alu_flags),
      .flush     (flush),
      .iss_valid (iss_valid),
      .iss_exec  (iss_exec),
      .iss_regw  (iss_regw),
      .iss_memw  (iss_memw),
      .iss_pcs   (iss_pcs),
      .flag_wb   (flag_wb),
      .flags     (flags),
      .undef_err (undef_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic rw, input logic mw, input logic pc);
      in_valid = v;
      in_cond  = c;
      in_flagw = fw;
      in_regw  = rw;
      in_memw  = mw;
      in_pcs   = pc;
      #1;
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      flush     = 1'b0;
      alu_flags = 4'h0;
      drive(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0);

      // 1: reset state, then an AL instruction issues the cycle after acceptance
      tick;
      tick;
      check("rst_flags", flags, 4'h0);
      check("rst_iss_valid", iss_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_flag_wb", flag_wb, 1'b0);
      check("rst_undef", undef_err, 1'b0);
      reset_n = 1'b1;
      drive(1'b1, 4'he, 2'b00, 1'b1, 1'b1, 1'b0);
      check("al_ready", in_ready, 1'b1);
      tick;
      check("al_iss_valid", iss_valid, 1'b1);
      check("al_iss_exec", iss_exec, 1'b1);
      check("al_iss_regw", iss_regw, 1'b1);
      check("al_iss_memw", iss_memw, 1'b1);

      // 2: ADDS then BEQ; BEQ waits on NZ
      alu_flags = 4'b0100;
      drive(1'b1, 4'he, 2'b11, 1'b1, 1'b0, 1'b0);          // T0 ADDS
      tick;                                                 // T1
      drive(1'b1, 4'h0, 2'b00, 1'b0, 1'b0, 1'b1);          // BEQ
      check("beq_stall_t1", in_ready, 1'b0);
      tick;                                                 // T2
      check("beq_t2_iss_valid", iss_valid, 1'b0);
      check("adds_flag_wb", flag_wb, 1'b1);
`ifdef COND_FLAG_BYPASS_EN
      check("beq_bypass_ready", in_ready, 1'b1);
      tick;                                                 // T3
      drive(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0);
      check("beq_iss_valid", iss_valid, 1'b1);
      check("beq_iss_exec", iss_exec, 1'b1);
      check("beq_iss_pcs", iss_pcs, 1'b1);
      check("adds_flags", flags, 4'b0100);
`else
      check("beq_stall_t2", in_ready, 1'b0);
      tick;                                                 // T3
      check("beq_t3_iss_valid", iss_valid, 1'b0);
      check("adds_flags", flags, 4'b0100);
      check("beq_ready_t3", in_ready, 1'b1);
      tick;                                                 // T4
      drive(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0);
      check("beq_iss_valid", iss_valid, 1'b1);
      check("beq_iss_exec", iss_exec, 1'b1);
      check("beq_iss_pcs", iss_pcs, 1'b1);
`endif

      // 3: clear flags, then MOVEQ squashed (and not a flag writer), MOVNE executes
      alu_flags = 4'b0000;
      drive(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0);
      tick;
      drive(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0);
      tick;
      tick;
      check("clr_flags", flags, 4'h0);
      alu_flags = 4'b1111;
      drive(1'b1, 4'h0, 2'b11, 1'b1, 1'b1, 1'b0);          // MOVEQ(S)
      check("moveq_ready", in_ready, 1'b1);
      tick;
      drive(1'b1, 4'h1, 2'b00, 1'b1, 1'b0, 1'b0);          // MOVNE
      check("moveq_iss_valid", iss_valid, 1'b1);
      check("moveq_iss_exec", iss_exec, 1'b0);
      check("moveq_iss_regw", iss_regw, 1'b0);
      check("moveq_iss_memw", iss_memw, 1'b0);
      check("movne_ready", in_ready, 1'b1);
      tick;
      drive(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0);
      check("movne_iss_exec", iss_exec, 1'b1);
      check("movne_iss_regw", iss_regw, 1'b1);
      check("moveq_no_wb", flag_wb, 1'b0);
      tick;
      check("moveq_flags_kept", flags, 4'h0);

      // 4: CV writer in flight; BGE stalls, BMI does not
      alu_flags = 4'b0011;
      drive(1'b1, 4'he, 2'b01, 1'b0, 1'b0, 1'b0);          // T0
      tick;                                                 // T1
      drive(1'b1, 4'ha, 2'b00, 1'b1, 1'b0, 1'b0);          // BGE
      check("bge_stall", in_ready, 1'b0);
      drive(1'b1, 4'h4, 2'b00, 1'b0, 1'b0, 1'b1);          // BMI
      check("bmi_ready", in_ready, 1'b1);
      tick;                                                 // T2
      drive(1'b0, 4'he, 2'b00, 1'b0, 1'b0, 1'b0);
      check("bmi_iss_valid", iss_valid, 1'b1);
      check("bmi_iss_exec", iss_exec, 1'b0);
      check("cv_flag_wb", flag_wb, 1'b1);
      tick;                                                 // T3
      check("cv_flags", flags, 4'b0011);

      // 5: two writers back-to-back, flush on the first tail
      alu_flags = 4'b1000;
      drive(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0);          // W1
      tick;
      drive(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0);          // W2
      tick;                                                 // W1 tail
      flush = 1'b1;
      drive(1'b1, 4'he, 2'b00, 1'b1, 1'b0, 1'b0);
      check("flush_ready", in_ready, 1'b0);
      check("flush_tail_wb", flag_wb, 1'b1);
      tick;
      flush     = 1'b0;
      alu_flags = 4'b0110;
      drive(1'b0, 4'hc, 2'b00, 1'b0, 1'b0, 1'b0);          // GT needs both groups
      check("flush_iss_valid", iss_valid, 1'b0);
      check("flush_flags", flags, 4'b1000);
      check("flush_counts_zero", in_ready, 1'b1);
      check("flush_w2_dropped", flag_wb, 1'b0);
      tick;
      check("flush_flags_hold", flags, 4'b1000);

      // 6: NV accepted -> undef pulse; then reset in the middle of a flag write
      drive(1'b1, 4'hf, 2'b11, 1'b1, 1'b0, 1'b0);
      check("nv_ready", in_ready, 1'b1);
      tick;
      drive(1'b0, 4'hc, 2'b00, 1'b0, 1'b0, 1'b0);
      check("nv_undef", undef_err, 1'b1);
      check("nv_iss_valid", iss_valid, 1'b1);
      check("nv_iss_exec", iss_exec, 1'b0);
      check("nv_iss_regw", iss_regw, 1'b0);
      check("nv_no_pending", in_ready, 1'b1);
      tick;
      check("nv_undef_pulse", undef_err, 1'b0);
      alu_flags = 4'b1111;
      drive(1'b1, 4'he, 2'b11, 1'b0, 1'b0, 1'b0);
      tick;
      drive(1'b0, 4'hc, 2'b00, 1'b0, 1'b0, 1'b0);
      check("mid_pending", in_ready, 1'b0);
      reset_n = 1'b0;
      #1;
      check("mid_rst_flags", flags, 4'h0);
      check("mid_rst_ready", in_ready, 1'b1);
      check("mid_rst_wb", flag_wb, 1'b0);
      check("mid_rst_iss", iss_valid, 1'b0);
      tick;
      reset_n = 1'b1;
      tick;
      check("post_rst_wb", flag_wb, 1'b0);
      tick;
      check("post_rst_flags", flags, 4'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
